// File: rtl/bp_table_ctrl_if.sv
// Update handshake from EX into the branch predictor write-port controller.
interface bp_table_ctrl_if #(
  parameter int IDX_W = 5
);
  logic             upd_valid;
  logic             upd_ready;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic [IDX_W-1:0] upd_bhsr;

  modport master (
    output upd_valid, upd_pc, upd_taken, upd_target, upd_bhsr,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_bhsr,
    output upd_ready
  );
endinterface

// File: rtl/bp_table_ctrl.sv
// Branch predictor table write-port controller: update FIFO, PHT RMW, GHR, table sweep.
// Optional BP_UPD_BYPASS_EN: an update arriving into an empty FIFO is written the same cycle.
//
// state | meaning
// INIT  | post-reset sweep writing every table entry
// IDLE  | predictions valid, draining queued updates
// CLEAR | requested sweep; FIFO and history already discarded
module bp_table_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 5,
  parameter int TAG_W      = 25
) (
  input  logic              clk,
  input  logic              reset,
  bp_table_ctrl_if.slave    upd,
  input  logic              clr_req,
  output logic              pred_en,
  output logic [IDX_W-1:0]  bhsr,
  output logic [IDX_W-1:0]  pht_rd_idx,
  input  logic [1:0]        pht_rd_data,
  output logic              tbl_we,
  output logic [IDX_W-1:0]  tbl_idx,
  output logic [TAG_W-1:0]  tbl_tag,
  output logic [31:0]       tbl_target,
  output logic              pht_we,
  output logic [IDX_W-1:0]  pht_idx,
  output logic [1:0]        pht_wdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [PTR_W:0]     occ;

  logic [31:0]        f_pc     [FIFO_DEPTH];
  logic               f_taken  [FIFO_DEPTH];
  logic [31:0]        f_target [FIFO_DEPTH];
  logic [IDX_W-1:0]   f_bhsr   [FIFO_DEPTH];

  logic               sweep, idle, clr, empty, full;
  logic               drain, bypass, retire, push, ready_int;
  logic [31:0]        head_pc, src_pc, src_target;
  logic               src_taken;
  logic [IDX_W-1:0]   head_hash, src_hash, src_bhsr;

  // Outputs are gated by reset so everything reads zero while it is held.
  assign sweep  = reset && (state_q != IDLE);
  assign idle   = reset && (state_q == IDLE);
  assign clr    = idle && clr_req;
  assign empty  = (occ == '0);
  assign full   = (occ == (PTR_W+1)'(FIFO_DEPTH));
  assign drain  = idle && !clr_req && !empty;

`ifdef BP_UPD_BYPASS_EN
  assign bypass = idle && !clr_req && empty && upd.upd_valid;
`else
  assign bypass = 1'b0;
`endif

  assign retire        = drain || bypass;
  assign ready_int     = idle && !clr_req && (!full || drain);
  assign upd.upd_ready = ready_int;
  assign push          = upd.upd_valid && ready_int && !bypass;
  assign pred_en       = idle;

  assign head_pc    = f_pc[rd_ptr];
  assign head_hash  = f_bhsr[rd_ptr] ^ head_pc[IDX_W+1:2];
  assign src_pc     = drain ? head_pc           : upd.upd_pc;
  assign src_taken  = drain ? f_taken[rd_ptr]   : upd.upd_taken;
  assign src_target = drain ? f_target[rd_ptr]  : upd.upd_target;
  assign src_bhsr   = drain ? f_bhsr[rd_ptr]    : upd.upd_bhsr;
  assign src_hash   = src_bhsr ^ src_pc[IDX_W+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    tbl_we     = 1'b0;
    tbl_idx    = '0;
    tbl_tag    = '0;
    tbl_target = '0;
    pht_we     = 1'b0;
    pht_idx    = '0;
    pht_wdata  = 2'b00;
    pht_rd_idx = '0;

    case (state_q)
      INIT, CLEAR: if (cnt == '1) state_d = IDLE;
      IDLE:        if (clr_req) state_d = CLEAR;
      default:     state_d = INIT;
    endcase

    if (sweep) begin
      tbl_we     = 1'b1;
      tbl_idx    = cnt;
      tbl_tag    = '1;
      pht_we     = 1'b1;
      pht_idx    = cnt;
      pht_wdata  = 2'b11;
    end else if (retire) begin
      pht_rd_idx = src_hash;
      pht_we     = 1'b1;
      pht_idx    = src_hash;
      if (src_taken)
        pht_wdata = (pht_rd_data == 2'b11) ? 2'b11 : pht_rd_data + 2'd1;
      else
        pht_wdata = (pht_rd_data == 2'b00) ? 2'b00 : pht_rd_data - 2'd1;
      if (src_taken) begin
        tbl_we     = 1'b1;
        tbl_idx    = src_pc[IDX_W+1:2];
        tbl_tag    = src_pc[31:IDX_W+2];
        tbl_target = src_target;
      end
    end else if (reset && !empty) begin
      pht_rd_idx = head_hash;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      bhsr   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (clr) begin
      cnt    <= '0;
      bhsr   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (sweep) cnt <= cnt + 1'b1;
      if (retire) bhsr <= {bhsr[IDX_W-2:0], src_taken};
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      case ({push, drain})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      f_pc[wr_ptr]     <= upd.upd_pc;
      f_taken[wr_ptr]  <= upd.upd_taken;
      f_target[wr_ptr] <= upd.upd_target;
      f_bhsr[wr_ptr]   <= upd.upd_bhsr;
    end
  end

endmodule
